// File: rtl/and_delay_sequencer.sv
// Measurement sequencer for the twelve 6-input AND gate variants: enables one ring
// oscillator, lets it settle, then counts its synchronized rising edges over a window.
module and_delay_sequencer #(
    parameter int WINDOW_W = 16,
    parameter int COUNT_W  = 16,
    parameter int SETTLE   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [3:0]          sel,
    input  logic [WINDOW_W-1:0] window,
    input  logic                osc_in,
    output logic [11:0]         var_sel,
    output logic                osc_en,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [COUNT_W-1:0]  count,
    output logic                saturated
);

    localparam int SET_W = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                sync1_r;
    logic                sync2_r;
    logic                sync3_r;
    logic                rise_s;
    logic                req_valid_s;
    logic                accept_s;
    logic                reject_s;
    logic [SET_W-1:0]    set_cnt_r;
    logic [WINDOW_W-1:0] win_cnt_r;
    logic [COUNT_W-1:0]  edge_cnt_r;
    logic [11:0]         var_sel_r;
    logic                osc_en_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;
    logic [COUNT_W-1:0]  count_r;
    logic                saturated_r;

    // Variant index is design*3 + effort; effort 3 never reaches this decoder.
    function automatic logic [11:0] decode_variant(input logic [3:0] s);
        logic [3:0] idx;
        idx = ({2'b00, s[3:2]} * 4'd3) + {2'b00, s[1:0]};
        return 12'd1 << idx;
    endfunction

    // Two-flop synchronizer plus one delay flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= osc_in;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    assign rise_s      = sync2_r & ~sync3_r;
    assign req_valid_s = (sel[1:0] != 2'd3) && (window != '0);
    assign accept_s    = (state_r == ST_IDLE) && start && req_valid_s;
    assign reject_s    = (state_r == ST_IDLE) && start && !req_valid_s;

    // Next-state logic; timers count down to 1 so each phase lasts its exact length.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_SETTLE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (set_cnt_r == SET_W'(1)) begin
                    state_s = ST_MEASURE;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            ST_MEASURE: begin
                if (win_cnt_r == WINDOW_W'(1)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_MEASURE;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Settle/window timers and the saturating edge counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_cnt_r  <= '0;
            win_cnt_r  <= '0;
            edge_cnt_r <= '0;
        end else if (accept_s) begin
            set_cnt_r  <= SET_W'(SETTLE);
            win_cnt_r  <= window;
            edge_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_SETTLE: set_cnt_r <= set_cnt_r - SET_W'(1);
                ST_MEASURE: begin
                    win_cnt_r <= win_cnt_r - WINDOW_W'(1);
                    if (rise_s && (edge_cnt_r != '1)) begin
                        edge_cnt_r <= edge_cnt_r + COUNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs; busy stays up through the done cycle so a new start
    // is only accepted once the result is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            var_sel_r   <= 12'd0;
            osc_en_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            count_r     <= '0;
            saturated_r <= 1'b0;
        end else begin
            osc_en_r <= (state_s == ST_SETTLE) || (state_s == ST_MEASURE);
            busy_r   <= (state_s != ST_IDLE) || (state_r == ST_DONE);
            done_r   <= (state_r == ST_DONE) || reject_s;
            if (accept_s) begin
                var_sel_r <= decode_variant(sel);
            end else if ((state_s == ST_IDLE) || (state_s == ST_DONE)) begin
                var_sel_r <= 12'd0;
            end else begin
                var_sel_r <= var_sel_r;
            end
            if (accept_s) begin
                err_r <= 1'b0;
            end else if (reject_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
            if (state_r == ST_DONE) begin
                count_r     <= edge_cnt_r;
                saturated_r <= &edge_cnt_r;
            end else begin
                count_r     <= count_r;
                saturated_r <= saturated_r;
            end
        end
    end

    assign var_sel   = var_sel_r;
    assign osc_en    = osc_en_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign count     = count_r;
    assign saturated = saturated_r;

endmodule
